// File: rtl/car_power_state_ctrl.sv
// Power/drive state owner: debounced power button (press-on, hold-off),
// per-cycle commit of the manual-drive decoder's next state, and a timed stall indicator.
//   state        | meaning
//   OFF          | engine off, decoder outputs ignored
//   NOT_STARTING | powered, engine not yet cranking
//   STARTING     | engine cranking
//   MOVING       | engine running, car in motion
module car_power_state_ctrl #(
  parameter int unsigned DEBOUNCE_TICKS = 1_000_000,
  parameter int unsigned HOLD_TICKS     = 100_000_000,
  parameter int unsigned STALL_TICKS    = 200_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_power_btn,
  input  logic       i_manual_en,
  input  logic [1:0] i_man_state_next,
  input  logic       i_man_break,
  output logic [1:0] o_state_cur,
  output logic       o_man_enable,
  output logic       o_power_on,
  output logic       o_stall_led
);

  localparam int DB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int STALL_W = $clog2(STALL_TICKS + 1);

  typedef enum logic [1:0] {
    ST_OFF          = 2'b00,
    ST_NOT_STARTING = 2'b01,
    ST_STARTING     = 2'b11,
    ST_MOVING       = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_btn_db;
  logic                 r_btn_db_d;
  logic [DB_W-1:0]      r_db_cnt;
  logic                 r_armed;
  logic [HOLD_W-1:0]    r_hold_cnt;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic                 r_stall_led;
  logic                 r_power_on;
  logic                 w_pwr_off;
  logic                 w_stall;
  logic                 w_pwr_on_fire;
  logic                 w_load_stall;
  logic                 w_power_on_evt;

  assign o_state_cur  = r_state;
  assign o_power_on   = r_power_on;
  assign o_stall_led  = r_stall_led;
  assign o_man_enable = i_manual_en & (r_state != ST_OFF);

  assign w_pwr_off     = (r_hold_cnt == HOLD_W'(HOLD_TICKS - 1)) & r_btn_db;
  assign w_stall       = o_man_enable & i_man_break;
  assign w_pwr_on_fire = (r_state == ST_OFF) & r_btn_db & ~r_btn_db_d & r_armed;

  always_comb begin
    w_state_next   = r_state;
    w_load_stall   = 1'b0;
    w_power_on_evt = 1'b0;
    if (w_pwr_off) begin
      w_state_next = ST_OFF;
    end else if (w_stall) begin
      w_state_next = ST_OFF;
      w_load_stall = 1'b1;
    end else if (o_man_enable) begin
      w_state_next = state_t'(i_man_state_next);
    end else if (w_pwr_on_fire) begin
      w_state_next   = ST_NOT_STARTING;
      w_power_on_evt = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_OFF;
      r_power_on  <= 1'b0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_btn_db    <= 1'b0;
      r_btn_db_d  <= 1'b0;
      r_db_cnt    <= '0;
      r_armed     <= 1'b0;
      r_hold_cnt  <= '0;
      r_stall_cnt <= '0;
      r_stall_led <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_power_on <= (w_state_next != ST_OFF);
      r_sync1    <= i_power_btn;
      r_sync2    <= r_sync1;
      r_btn_db_d <= r_btn_db;

      // any bounce back to the debounced level restarts the stability count
      if (r_sync2 != r_btn_db) begin
        if (r_db_cnt == DB_W'(DEBOUNCE_TICKS - 1)) begin
          r_btn_db <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end

      if (w_power_on_evt) begin
        r_armed <= 1'b0;
      end else if (!r_btn_db) begin
        r_armed <= 1'b1;
      end

      if (w_pwr_off) begin
        r_hold_cnt <= '0;
      end else if (r_btn_db && r_armed && (r_state != ST_OFF)) begin
        if (r_hold_cnt != HOLD_W'(HOLD_TICKS)) begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end else begin
        r_hold_cnt <= '0;
      end

      if (w_power_on_evt) begin
        r_stall_led <= 1'b0;
        r_stall_cnt <= '0;
      end else if (w_load_stall) begin
        r_stall_led <= 1'b1;
        r_stall_cnt <= STALL_W'(STALL_TICKS);
      end else if (r_stall_led) begin
        if (r_stall_cnt == STALL_W'(1)) begin
          r_stall_led <= 1'b0;
        end
        r_stall_cnt <= r_stall_cnt - STALL_W'(1);
      end
    end
  end

endmodule
